// File: rtl/grant_sequencer_if.sv
// Grant handshake bundle between grant_sequencer and its consumer.
// Master offers grants; slave accepts them and signals completion.
interface grant_sequencer_if #(
   parameter int IW = 2
) ();
   logic          grant_valid;
   logic [IW-1:0] grant_idx;
   logic          grant_ready;
   logic          done;
   logic          busy;

   modport master (
      output grant_valid, grant_idx, busy,
      input  grant_ready, done
   );

   modport slave (
      input  grant_valid, grant_idx, busy,
      output grant_ready, done
   );
endinterface

// File: rtl/grant_sequencer.sv
// Sticky request collector and grant FSM wrapped around an external
// highest-index priority encoder.
module grant_sequencer #(
   parameter int W     = 4,
   parameter int CNT_W = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [W-1:0]          req_pulse,
   output logic [W-1:0]          request_vec,
   input  logic [$clog2(W)-1:0]  granted_idx,
   input  logic                  error,
   grant_sequencer_if.master     gnt,
   output logic [CNT_W-1:0]      serviced_count
);
   localparam int IW = $clog2(W);

   typedef enum logic [1:0] {
      IDLE,
      OFFER,
      BUSY
   } state_e;

   state_e            state_q, state_d;
   logic [W-1:0]      pend_q, pend_d;
   logic [W-1:0]      clr;
   logic [IW-1:0]     idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         pend_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      clr     = '0;
      unique case (state_q)
         IDLE: begin
            if (!error) begin
               idx_d   = granted_idx;
               state_d = OFFER;
            end
         end
         OFFER: begin
            if (gnt.grant_ready) begin
               clr[idx_q] = 1'b1;
               state_d    = BUSY;
            end
         end
         BUSY: begin
            if (gnt.done) begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A new pulse on the bit being cleared keeps it pending
      pend_d = (pend_q & ~clr) | req_pulse;
   end

   assign request_vec     = pend_q;
   assign gnt.grant_valid = (state_q == OFFER);
   assign gnt.busy        = (state_q == BUSY);
   assign gnt.grant_idx   = idx_q;
   assign serviced_count  = cnt_q;
endmodule

// File: tb/tb_grant_sequencer.sv
// Directed vector bench for grant_sequencer with a behavioural encoder.
// A second instance with a 2-bit counter checks wrap-around.
module tb_grant_sequencer;
   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] rv, rv2;
   logic [1:0] gidx, gidx2;
   logic       err, err2;
   logic [7:0] cnt;
   logic [1:0] cnt2;

   int checks = 0;
   int errors = 0;

   grant_sequencer_if #(.IW(2)) gif ();
   grant_sequencer_if #(.IW(2)) gif2 ();

   grant_sequencer #(.W(4), .CNT_W(8)) dut (
      .clock          (clk),
      .reset          (rst),
      .req_pulse      (req),
      .request_vec    (rv),
      .granted_idx    (gidx),
      .error          (err),
      .gnt            (gif),
      .serviced_count (cnt)
   );

   grant_sequencer #(.W(4), .CNT_W(2)) dut2 (
      .clock          (clk),
      .reset          (rst),
      .req_pulse      (req),
      .request_vec    (rv2),
      .granted_idx    (gidx2),
      .error          (err2),
      .gnt            (gif2),
      .serviced_count (cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      gidx = '0;
      err  = (rv == 4'b0);
      for (int i = 0; i < 4; i++)
         if (rv[i]) gidx = i[1:0];
   end

   always_comb begin
      gidx2 = '0;
      err2  = (rv2 == 4'b0);
      for (int i = 0; i < 4; i++)
         if (rv2[i]) gidx2 = i[1:0];
   end

   typedef struct {
      logic [3:0] req;
      logic       rdy;
      logic       dn;
      logic       v;
      logic [1:0] idx;
      logic       b;
      logic [3:0] rv;
      logic [7:0] cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [3:0] r, input logic rd,
                      input logic d, input logic v,
                      input logic [1:0] ix, input logic b,
                      input logic [3:0] pv, input logic [7:0] c);
      vec_t e;
      e.req = r; e.rdy = rd; e.dn = d; e.v = v;
      e.idx = ix; e.b = b; e.rv = pv; e.cnt = c;
      tbl.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic v,
                          input logic [1:0] ix, input logic b,
                          input logic [3:0] pv, input logic [7:0] c);
      chk({tag, " valid"}, {7'b0, gif.grant_valid}, {7'b0, v});
      chk({tag, " idx"}, {6'b0, gif.grant_idx}, {6'b0, ix});
      chk({tag, " busy"}, {7'b0, gif.busy}, {7'b0, b});
      chk({tag, " reqvec"}, {4'b0, rv}, {4'b0, pv});
      chk({tag, " count"}, cnt, c);
      chk({tag, " count2"}, {6'b0, cnt2}, {6'b0, c[1:0]});
   endtask

   task automatic step(input logic [3:0] r, input logic rd,
                       input logic d);
      req             = r;
      gif.grant_ready = rd;
      gif.done        = d;
      gif2.grant_ready = rd;
      gif2.done        = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // single pulse on client 2, done three cycles after accept
      add(4'b0100, 1, 0, 0, 2'd0, 0, 4'b0100, 8'd0);
      add(4'b0000, 1, 0, 1, 2'd2, 0, 4'b0100, 8'd0);
      add(4'b0000, 1, 0, 0, 2'd2, 1, 4'b0000, 8'd0);
      add(4'b0000, 1, 0, 0, 2'd2, 1, 4'b0000, 8'd0);
      add(4'b0000, 1, 0, 0, 2'd2, 1, 4'b0000, 8'd0);
      add(4'b0000, 1, 1, 0, 2'd2, 0, 4'b0000, 8'd1);
      add(4'b0000, 1, 0, 0, 2'd2, 0, 4'b0000, 8'd1);
      // 1011 with ready/done tied high: grants 3, 1, 0
      add(4'b1011, 1, 1, 0, 2'd2, 0, 4'b1011, 8'd1);
      add(4'b0000, 1, 1, 1, 2'd3, 0, 4'b1011, 8'd1);
      add(4'b0000, 1, 1, 0, 2'd3, 1, 4'b0011, 8'd1);
      add(4'b0000, 1, 1, 0, 2'd3, 0, 4'b0011, 8'd2);
      add(4'b0000, 1, 1, 1, 2'd1, 0, 4'b0011, 8'd2);
      add(4'b0000, 1, 1, 0, 2'd1, 1, 4'b0001, 8'd2);
      add(4'b0000, 1, 1, 0, 2'd1, 0, 4'b0001, 8'd3);
      add(4'b0000, 1, 1, 1, 2'd0, 0, 4'b0001, 8'd3);
      add(4'b0000, 1, 1, 0, 2'd0, 1, 4'b0000, 8'd3);
      add(4'b0000, 1, 1, 0, 2'd0, 0, 4'b0000, 8'd4);
      add(4'b0000, 1, 1, 0, 2'd0, 0, 4'b0000, 8'd4);
      // backpressure on idx 1 while client 3 arrives
      add(4'b0010, 0, 0, 0, 2'd0, 0, 4'b0010, 8'd4);
      add(4'b0000, 0, 0, 1, 2'd1, 0, 4'b0010, 8'd4);
      add(4'b1000, 0, 0, 1, 2'd1, 0, 4'b1010, 8'd4);
      for (int i = 0; i < 8; i++)
         add(4'b0000, 0, 0, 1, 2'd1, 0, 4'b1010, 8'd4);
      add(4'b0000, 1, 0, 0, 2'd1, 1, 4'b1000, 8'd4);
      add(4'b0000, 0, 1, 0, 2'd1, 0, 4'b1000, 8'd5);
      add(4'b0000, 0, 0, 1, 2'd3, 0, 4'b1000, 8'd5);
      add(4'b0000, 1, 0, 0, 2'd3, 1, 4'b0000, 8'd5);
      add(4'b0000, 0, 1, 0, 2'd3, 0, 4'b0000, 8'd6);
      // set wins over clear on idx 2
      add(4'b0100, 0, 0, 0, 2'd3, 0, 4'b0100, 8'd6);
      add(4'b0000, 0, 0, 1, 2'd2, 0, 4'b0100, 8'd6);
      add(4'b0100, 1, 0, 0, 2'd2, 1, 4'b0100, 8'd6);
      add(4'b0000, 0, 1, 0, 2'd2, 0, 4'b0100, 8'd7);
      add(4'b0000, 0, 0, 1, 2'd2, 0, 4'b0100, 8'd7);
      add(4'b0000, 1, 0, 0, 2'd2, 1, 4'b0000, 8'd7);
      add(4'b0011, 0, 0, 0, 2'd2, 1, 4'b0011, 8'd7);

      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(4'b0, 1'b0, 1'b0);
         chk_all($sformatf("reset%0d", i), 0, 2'd0, 0, 4'b0, 8'd0);
      end
      rst = 1'b0;

      foreach (tbl[i]) begin
         step(tbl[i].req, tbl[i].rdy, tbl[i].dn);
         chk_all($sformatf("vec%0d", i), tbl[i].v, tbl[i].idx,
                 tbl[i].b, tbl[i].rv, tbl[i].cnt);
      end

      // reset while BUSY with 0011 pending drops everything
      rst = 1'b1;
      step(4'b0000, 1'b1, 1'b0);
      chk_all("midrst", 0, 2'd0, 0, 4'b0, 8'd0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(4'b0000, 1'b1, 1'b0);
         chk_all($sformatf("postrst%0d", i), 0, 2'd0, 0, 4'b0, 8'd0);
      end
      step(4'b0001, 1'b0, 1'b0);
      chk_all("newreq0", 0, 2'd0, 0, 4'b0001, 8'd0);
      step(4'b0000, 1'b0, 1'b0);
      chk_all("newreq1", 1, 2'd0, 0, 4'b0001, 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
